// File: rtl/fsk_rx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fsk_rx_sequencer
// Purpose  : Decides FSK bits by counting rising edges per fixed-length bit
//            window, hunts for a sync word, then assembles Hamming(7,4)
//            frames and hands them downstream with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fsk_rx_sequencer #(
    parameter int         BIT_CYCLES     = 33,
    parameter int         EDGE_THRESH    = 8,
    parameter logic [7:0] SYNC_WORD      = 8'hA5,
    parameter int         FRAMES_PER_PKT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_enable,
    input  logic       io_input,
    input  logic       io_frame_ready,
    input  logic       io_clear_ovf,
    output logic       io_frame_valid,
    output logic [6:0] io_frame_bits,
    output logic       io_frame_last,
    output logic       io_overflow,
    output logic       io_locked,
    output logic [1:0] io_state
);

    localparam int WIN_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int FRM_W = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BIT_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_PKT - 1);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
    localparam logic [9:0]       THRESH   = 10'(EDGE_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_RECV = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prev_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [8:0]       edge_q, edge_d;
    logic [7:0]       sync_q, sync_d;
    // Only the six earlier bits of a frame need storing; the seventh is the
    // bit being decided in the completing cycle.
    logic [5:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [FRM_W-1:0] frmcnt_q, frmcnt_d;
    logic             valid_q, valid_d;
    logic [6:0]       bits_q, bits_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;

    logic       rise;
    logic       running;
    logic       win_end;
    logic [8:0] edge_inc;
    logic       bit_dec;
    logic [7:0] sync_next;
    logic [6:0] frame_word;
    logic       frame_last;
    logic       frame_done;

    assign rise       = io_input & ~prev_q;
    assign running    = io_enable && (state_q != ST_IDLE);
    assign win_end    = running && (win_q == WIN_LAST);
    // Saturating count that already includes an edge landing on this cycle
    assign edge_inc   = (rise && (edge_q != 9'h1FF)) ? (edge_q + 9'd1) : edge_q;
    assign bit_dec    = ({1'b0, edge_inc} >= THRESH);
    assign sync_next  = {sync_q[6:0], bit_dec};
    assign frame_word = {shift_q, bit_dec};
    assign frame_last = (frmcnt_q == FRM_LAST);

    // Next-state: window timing, sequencing and output handshake
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        edge_d     = edge_q;
        sync_d     = sync_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        frmcnt_d   = frmcnt_q;
        valid_d    = valid_q;
        bits_d     = bits_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
        frame_done = 1'b0;

        if (running) begin
            win_d  = win_end ? '0 : (win_q + WIN_ONE);
            edge_d = win_end ? 9'd0 : edge_inc;
        end

        if (!io_enable) begin
            state_d  = ST_IDLE;
            win_d    = '0;
            edge_d   = 9'd0;
            sync_d   = 8'd0;
            shift_d  = 6'd0;
            bitcnt_d = 3'd0;
            frmcnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HUNT;
                    sync_d  = 8'd0;
                end
                ST_HUNT: begin
                    if (win_end) begin
                        sync_d = sync_next;
                        if (sync_next == SYNC_WORD) begin
                            state_d  = ST_RECV;
                            bitcnt_d = 3'd0;
                            frmcnt_d = '0;
                            shift_d  = 6'd0;
                        end
                    end
                end
                ST_RECV: begin
                    if (win_end) begin
                        shift_d = frame_word[5:0];
                        if (bitcnt_q == 3'd6) begin
                            frame_done = 1'b1;
                            bitcnt_d   = 3'd0;
                            if (frame_last) begin
                                frmcnt_d = '0;
                                state_d  = ST_HUNT;
                                sync_d   = 8'd0;
                            end else begin
                                frmcnt_d = frmcnt_q + FRM_ONE;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A held frame is never overwritten unless it is accepted this cycle
        if (frame_done && (!valid_q || io_frame_ready)) begin
            valid_d = 1'b1;
            bits_d  = frame_word;
            last_d  = frame_last;
        end else if (valid_q && io_frame_ready) begin
            valid_d = 1'b0;
        end

        // Setting the flag wins over a simultaneous clear
        if (frame_done && valid_q && !io_frame_ready) begin
            ovf_d = 1'b1;
        end else if (io_clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= 1'b0;
            win_q    <= '0;
            edge_q   <= 9'd0;
            sync_q   <= 8'd0;
            shift_q  <= 6'd0;
            bitcnt_q <= 3'd0;
            frmcnt_q <= '0;
            valid_q  <= 1'b0;
            bits_q   <= 7'd0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= io_input;
            win_q    <= win_d;
            edge_q   <= edge_d;
            sync_q   <= sync_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            frmcnt_q <= frmcnt_d;
            valid_q  <= valid_d;
            bits_q   <= bits_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    assign io_frame_valid = valid_q;
    assign io_frame_bits  = bits_q;
    assign io_frame_last  = last_q;
    assign io_overflow    = ovf_q;
    assign io_locked      = (state_q == ST_RECV);
    assign io_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_rx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fsk_rx_sequencer
// Purpose  : Self-checking bench for fsk_rx_sequencer; bit-level reference
//            model fed with the intended bit of each generated window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_rx_sequencer;

    localparam int         BITC = 33;
    localparam int         THR  = 8;
    localparam int         NFR  = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_enable = 1'b0;
    logic       io_input = 1'b0;
    logic       io_frame_ready = 1'b0;
    logic       io_clear_ovf = 1'b0;
    logic       io_frame_valid;
    logic [6:0] io_frame_bits;
    logic       io_frame_last;
    logic       io_overflow;
    logic       io_locked;
    logic [1:0] io_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: protocol-level view (0=IDLE 1=HUNT 2=RECV)
    int m_state, m_sync, m_shift, m_nbits, m_nfr, m_obits;
    bit m_valid, m_last, m_ovf;

    bit g_rand = 1'b0;
    bit g_first_valid;

    fsk_rx_sequencer #(
        .BIT_CYCLES    (BITC),
        .EDGE_THRESH   (THR),
        .SYNC_WORD     (SYNC),
        .FRAMES_PER_PKT(NFR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_enable     (io_enable),
        .io_input      (io_input),
        .io_frame_ready(io_frame_ready),
        .io_clear_ovf  (io_clear_ovf),
        .io_frame_valid(io_frame_valid),
        .io_frame_bits (io_frame_bits),
        .io_frame_last (io_frame_last),
        .io_overflow   (io_overflow),
        .io_locked     (io_locked),
        .io_state      (io_state)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_state = 0; m_sync = 0; m_shift = 0; m_nbits = 0; m_nfr = 0;
        m_obits = 0; m_valid = 0; m_last = 0; m_ovf = 0;
    endtask

    // One clock: predict the model, advance the DUT, compare all outputs
    task automatic step(input bit is_end, input bit dbit);
        int ns = m_state;
        int nsync = m_sync;
        int nshift = m_shift;
        int nb = m_nbits;
        int nf = m_nfr;
        int word = 0;
        int nob = m_obits;
        bit done = 1'b0;
        bit lastf = 1'b0;
        bit nvalid = m_valid;
        bit nlast = m_last;
        bit novf = m_ovf;
        logic [12:0] exp_v, act_v;
        if (!io_enable) begin
            ns = 0; nsync = 0; nshift = 0; nb = 0; nf = 0;
        end else if (m_state == 0) begin
            ns = 1; nsync = 0;
        end else if (is_end) begin
            if (m_state == 1) begin
                nsync = ((m_sync << 1) | int'(dbit)) & 255;
                if (nsync == int'(SYNC)) begin ns = 2; nb = 0; nf = 0; end
            end else begin
                word = ((m_shift << 1) | int'(dbit)) & 127;
                nshift = word;
                nb = m_nbits + 1;
                if (nb == 7) begin
                    done = 1'b1; nb = 0; nf = m_nfr + 1;
                    lastf = (nf == NFR);
                    if (lastf) begin nf = 0; ns = 1; nsync = 0; end
                end
            end
        end
        if (done && (!m_valid || io_frame_ready)) begin
            nvalid = 1'b1; nob = word; nlast = lastf;
        end else if (m_valid && io_frame_ready) begin
            nvalid = 1'b0;
        end
        if (done && m_valid && !io_frame_ready) novf = 1'b1;
        else if (io_clear_ovf) novf = 1'b0;

        @(posedge clock);
        #1;
        m_state = ns; m_sync = nsync; m_shift = nshift; m_nbits = nb; m_nfr = nf;
        m_valid = nvalid; m_obits = nob; m_last = nlast; m_ovf = novf;

        exp_v = {2'(m_state), (m_state == 2), m_valid, 7'(m_obits), m_last, m_ovf};
        act_v = {io_state, io_locked, io_frame_valid, io_frame_bits, io_frame_last, io_overflow};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t actual=%b required=%b (state,locked,valid,bits,last,ovf)",
                     $time, act_v, exp_v);
        end
    endtask

    // One bit window with n rising edges; optionally the last edge on the final cycle
    task automatic send_window(input int n, input bit elast, input int rdy_end,
                               input bit clr_first, input bit clr_end);
        int k = elast ? n - 1 : n;
        for (int c = 0; c < BITC; c++) begin
            io_input = ((c % 2 == 1) && (c / 2 < k)) || (elast && c == BITC - 1);
            if (g_rand) begin
                io_frame_ready = 1'($urandom_range(1, 0));
                io_clear_ovf   = ($urandom_range(7, 0) == 0);
            end else begin
                io_clear_ovf = (clr_first && c == 0) || (clr_end && c == BITC - 1);
                if (rdy_end >= 0 && c == BITC - 1) io_frame_ready = (rdy_end != 0);
            end
            step(c == BITC - 1, n >= THR);
            if (c == 0) g_first_valid = io_frame_valid;
        end
        if (!g_rand) io_clear_ovf = 1'b0;
    endtask

    task automatic send_bit(input bit b, input int rdy_end, input bit clr_first, input bit clr_end);
        int n;
        bit el;
        n  = b ? int'($urandom_range(16, THR)) : int'($urandom_range(THR - 1, 0));
        el = (n > 0) && ($urandom_range(1, 0) == 1);
        send_window(n, el, rdy_end, clr_first, clr_end);
    endtask

    task automatic send_bits(input int value, input int width, input int rdy_end,
                             input bit clr_first, input bit clr_end);
        for (int i = width - 1; i >= 0; i--) begin
            send_bit(((value >> i) & 1) == 1, (i == 0) ? rdy_end : -1,
                     clr_first && (i == width - 1), clr_end && (i == 0));
        end
    endtask

    task automatic go_idle();
        io_input = 1'b0; io_enable = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic enable_run();
        io_input = 1'b0; io_enable = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic resync();
        go_idle();
        enable_run();
        send_bits(int'(SYNC), 8, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({io_state, io_locked, io_frame_valid, io_frame_bits, io_frame_last, io_overflow} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values actual=%b required=0",
                     {io_state, io_locked, io_frame_valid, io_frame_bits, io_frame_last, io_overflow});
        end
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        go_idle();
    endtask

    task automatic test_sync();
        io_frame_ready = 1'b1;
        enable_run();
        send_bits(int'(SYNC >> 1), 7, -1, 1'b0, 1'b0);
        n_checks++;
        if (io_locked !== 1'b0) begin
            n_fail++; $display("FAIL sync_early_lock actual=%b required=0", io_locked);
        end
        n_checks++;
        if (io_state !== 2'd1) begin
            n_fail++; $display("FAIL sync_hunt_state actual=%0d required=1", io_state);
        end
        send_bit(SYNC[0], -1, 1'b0, 1'b0);
        n_checks++;
        if (io_locked !== 1'b1) begin
            n_fail++; $display("FAIL sync_lock actual=%b required=1", io_locked);
        end
        n_checks++;
        if (io_state !== 2'd2) begin
            n_fail++; $display("FAIL sync_recv_state actual=%0d required=2", io_state);
        end
    endtask

    task automatic test_frame();
        send_bits(7'b1011010, 7, -1, 1'b0, 1'b0);
        n_checks++;
        if (io_frame_bits !== 7'b1011010) begin
            n_fail++; $display("FAIL frame_bits actual=%b required=1011010", io_frame_bits);
        end
        n_checks++;
        if (io_frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL frame_valid actual=%b required=1", io_frame_valid);
        end
        n_checks++;
        if (io_frame_last !== 1'b0) begin
            n_fail++; $display("FAIL frame_last actual=%b required=0", io_frame_last);
        end
    endtask

    task automatic test_threshold();
        send_window(8, 1'b1, -1, 1'b0, 1'b0);
        n_checks++;
        if (g_first_valid !== 1'b0) begin
            n_fail++; $display("FAIL frame_valid_one_cycle actual=%b required=0", g_first_valid);
        end
        send_window(7, 1'b0, -1, 1'b0, 1'b0);
        send_window(8, 1'b1, -1, 1'b0, 1'b0);
        send_window(7, 1'b1, -1, 1'b0, 1'b0);
        send_window(8, 1'b0, -1, 1'b0, 1'b0);
        send_window(7, 1'b0, -1, 1'b0, 1'b0);
        send_window(8, 1'b1, -1, 1'b0, 1'b0);
        n_checks++;
        if (io_frame_bits !== 7'b1010101) begin
            n_fail++; $display("FAIL threshold_bits actual=%b required=1010101", io_frame_bits);
        end
        n_checks++;
        if (io_frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL threshold_valid actual=%b required=1", io_frame_valid);
        end
    endtask

    task automatic test_overflow();
        int wa, wb, wc, wd;
        wa = int'($urandom_range(127, 0));
        wb = int'($urandom_range(127, 0));
        wc = int'($urandom_range(127, 0));
        wd = int'($urandom_range(127, 0));
        resync();
        io_frame_ready = 1'b0;
        send_bits(wa, 7, -1, 1'b0, 1'b0);
        send_bits(wb, 7, -1, 1'b0, 1'b0);
        n_checks++;
        if (io_frame_bits !== 7'(wa)) begin
            n_fail++; $display("FAIL ovf_held_bits actual=%b required=%b", io_frame_bits, 7'(wa));
        end
        n_checks++;
        if (io_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set actual=%b required=1", io_overflow);
        end
        n_checks++;
        if (io_frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_valid_held actual=%b required=1", io_frame_valid);
        end
        // clear at the start, ready only on the completing cycle
        send_bits(wc, 7, 1, 1'b1, 1'b0);
        n_checks++;
        if (io_frame_bits !== 7'(wc)) begin
            n_fail++; $display("FAIL ready_on_done_bits actual=%b required=%b", io_frame_bits, 7'(wc));
        end
        n_checks++;
        if (io_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ready_on_done_ovf actual=%b required=0", io_overflow);
        end
        io_frame_ready = 1'b0;
        // drop coincides with a clear request: flag must stay set
        send_bits(wd, 7, -1, 1'b0, 1'b1);
        n_checks++;
        if (io_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_beats_clear actual=%b required=1", io_overflow);
        end
        n_checks++;
        if (io_frame_bits !== 7'(wc)) begin
            n_fail++; $display("FAIL ovf_second_hold actual=%b required=%b", io_frame_bits, 7'(wc));
        end
        io_frame_ready = 1'b1;
    endtask

    task automatic test_packet();
        resync();
        io_frame_ready = 1'b1;
        for (int f = 0; f < NFR; f++) begin
            send_bits(int'($urandom_range(127, 0)), 7, -1, (f == 0), 1'b0);
            if (f == NFR - 2) begin
                n_checks++;
                if (io_frame_last !== 1'b0) begin
                    n_fail++; $display("FAIL pkt_not_last actual=%b required=0", io_frame_last);
                end
            end
        end
        n_checks++;
        if (io_frame_last !== 1'b1) begin
            n_fail++; $display("FAIL pkt_last actual=%b required=1", io_frame_last);
        end
        n_checks++;
        if (io_state !== 2'd1) begin
            n_fail++; $display("FAIL pkt_back_to_hunt actual=%0d required=1", io_state);
        end
        send_bits(8'hA4, 8, -1, 1'b0, 1'b0);
        n_checks++;
        if (io_state !== 2'd1) begin
            n_fail++; $display("FAIL near_sync_stays_hunt actual=%0d required=1", io_state);
        end
    endtask

    task automatic test_random();
        g_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                io_enable = 1'b0;
                for (int d = 0; d < int'($urandom_range(3, 1)); d++) step(1'b0, 1'b0);
                enable_run();
            end
            send_bits(int'($urandom_range(255, 0)), 8, -1, 1'b0, 1'b0);
            send_bits(int'(SYNC), 8, -1, 1'b0, 1'b0);
            for (int j = 0; j < int'($urandom_range(30, 5)); j++) begin
                send_bit(($urandom_range(1, 0) == 1), -1, 1'b0, 1'b0);
            end
        end
        g_rand = 1'b0;
        io_clear_ovf = 1'b0;
        io_frame_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        int w;
        resync();
        io_frame_ready = 1'b0;
        send_bits(int'($urandom_range(127, 0)), 7, -1, 1'b0, 1'b0);
        send_bits(int'($urandom_range(7, 0)), 3, -1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({io_state, io_locked, io_frame_valid, io_frame_bits, io_frame_last, io_overflow} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_midframe actual=%b required=0",
                     {io_state, io_locked, io_frame_valid, io_frame_bits, io_frame_last, io_overflow});
        end
        io_enable = 1'b0;
        io_input  = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        enable_run();
        send_bits(int'(SYNC), 8, -1, 1'b0, 1'b0);
        w = int'($urandom_range(127, 0));
        send_bits(w, 7, -1, 1'b0, 1'b0);
        io_enable = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        n_checks++;
        if (io_frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL disable_keeps_valid actual=%b required=1", io_frame_valid);
        end
        n_checks++;
        if (io_state !== 2'd0) begin
            n_fail++; $display("FAIL disable_idle actual=%0d required=0", io_state);
        end
        n_checks++;
        if (io_frame_bits !== 7'(w)) begin
            n_fail++; $display("FAIL disable_bits_stable actual=%b required=%b", io_frame_bits, 7'(w));
        end
        io_frame_ready = 1'b1;
        step(1'b0, 1'b0);
        n_checks++;
        if (io_frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL disable_handshake actual=%b required=0", io_frame_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sync();
        test_frame();
        test_threshold();
        test_overflow();
        test_packet();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
